// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: PLL lock input plus the supervisor's sequencing and
// health outputs. The supervisor uses the master modport, and the PLL and
// system side uses the slave modport.
interface pll_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [3:0] retry_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output lock_lost,
    output fault,
    output retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  lock_lost,
    input  fault,
    input  retry_count
  );
endinterface

// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences the PLL reset and watches its lock output.
// The block holds the system reset until lock has been stable. It
// re-sequences the PLL after a lock timeout or a loss of lock, and after
// RETRY_MAX failed attempts it latches a fault that only rst can clear.
// Optional feature macro: PLL_SUPERVISOR_LOCK_FILTER_EN. When it is
// defined, RUN declares lock loss only after 4 consecutive low lock cycles.
module pll_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX           = 7
) (
  input  logic                 i_refclk,
  input  logic                 i_rst,
  pll_supervisor_if.master     io_sup
);

  localparam int PW = (RST_PULSE_CYCLES    > 1) ? $clog2(RST_PULSE_CYCLES)    : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int SW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;

  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM   = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_sync1;
  logic          r_lk;
  logic [PW-1:0] r_pulse_cnt;
  logic [PW-1:0] w_pulse_cnt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer;
  logic [SW-1:0] r_stable_cnt;
  logic [SW-1:0] w_stable_cnt;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry;
  logic [3:0]    w_retry_inc;
  logic          w_lock_loss;
`ifdef PLL_SUPERVISOR_LOCK_FILTER_EN
  logic [1:0]    r_low_cnt;
  logic [1:0]    w_low_cnt;
`endif

  logic r_pll_rst;
  logic r_sys_rst;
  logic r_ready;
  logic r_lock_lost;
  logic r_fault;
  logic w_pll_rst;
  logic w_sys_rst;
  logic w_ready;
  logic w_fault;

  // Bring the asynchronous lock input into refclk with two flops.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_lk    <= 1'b0;
    end else begin
      r_sync1 <= io_sup.pll_locked;
      r_lk    <= r_sync1;
    end
  end

  // Next-state logic and counter updates. Each counter is cleared on
  // entry to the state that uses it.
  always_comb begin
    w_next_state = r_state;
    w_pulse_cnt  = r_pulse_cnt;
    w_timer      = r_timer;
    w_stable_cnt = r_stable_cnt;
    w_retry      = r_retry;
    w_retry_inc  = r_retry + 4'd1;
    w_lock_loss  = 1'b0;
`ifdef PLL_SUPERVISOR_LOCK_FILTER_EN
    w_low_cnt    = r_low_cnt;
`endif
    case (r_state)
      S_RESET_PLL: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_next_state = S_WAIT_LOCK;
          w_timer      = '0;
        end else begin
          w_pulse_cnt  = r_pulse_cnt + PW'(1'b1);
        end
      end
      S_WAIT_LOCK: begin
        // When lock and timeout coincide, lock wins.
        if (r_lk) begin
          w_next_state = S_STABILIZE;
          w_stable_cnt = '0;
        end else if (r_timer == TIMER_LAST) begin
          w_retry = w_retry_inc;
          if (w_retry_inc == RETRY_LIM) begin
            w_next_state = S_FAULT;
          end else begin
            w_next_state = S_RESET_PLL;
            w_pulse_cnt  = '0;
          end
        end else begin
          w_timer = r_timer + TW'(1'b1);
        end
      end
      S_STABILIZE: begin
        // A single low cycle restarts the timeout budget but keeps retries.
        if (!r_lk) begin
          w_next_state = S_WAIT_LOCK;
          w_timer      = '0;
        end else if (r_stable_cnt == STABLE_LAST) begin
          w_next_state = S_RUN;
          w_retry      = 4'd0;
`ifdef PLL_SUPERVISOR_LOCK_FILTER_EN
          w_low_cnt    = 2'd0;
`endif
        end else begin
          w_stable_cnt = r_stable_cnt + SW'(1'b1);
        end
      end
      S_RUN: begin
`ifdef PLL_SUPERVISOR_LOCK_FILTER_EN
        if (!r_lk) begin
          if (r_low_cnt == 2'd3) begin
            w_lock_loss = 1'b1;
          end else begin
            w_low_cnt   = r_low_cnt + 2'd1;
          end
        end else begin
          w_low_cnt = 2'd0;
        end
`else
        w_lock_loss = !r_lk;
`endif
        if (w_lock_loss) begin
          w_next_state = S_RESET_PLL;
          w_pulse_cnt  = '0;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FAULT: begin
        w_next_state = S_FAULT;
        w_retry      = RETRY_LIM;
      end
      default: begin
        w_next_state = S_RESET_PLL;
        w_pulse_cnt  = '0;
      end
    endcase
  end

  // Decode the output levels for the state being entered.
  always_comb begin
    w_pll_rst = 1'b1;
    w_sys_rst = 1'b1;
    w_ready   = 1'b0;
    w_fault   = 1'b0;
    case (w_next_state)
      S_RESET_PLL: w_pll_rst = 1'b1;
      S_WAIT_LOCK: w_pll_rst = 1'b0;
      S_STABILIZE: w_pll_rst = 1'b0;
      S_RUN: begin
        w_pll_rst = 1'b0;
        w_sys_rst = 1'b0;
        w_ready   = 1'b1;
      end
      S_FAULT:     w_fault   = 1'b1;
      default:     w_pll_rst = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state <= S_RESET_PLL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counter and retry registers.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_pulse_cnt  <= '0;
      r_timer      <= '0;
      r_stable_cnt <= '0;
      r_retry      <= 4'd0;
`ifdef PLL_SUPERVISOR_LOCK_FILTER_EN
      r_low_cnt    <= 2'd0;
`endif
    end else begin
      r_pulse_cnt  <= w_pulse_cnt;
      r_timer      <= w_timer;
      r_stable_cnt <= w_stable_cnt;
      r_retry      <= w_retry;
`ifdef PLL_SUPERVISOR_LOCK_FILTER_EN
      r_low_cnt    <= w_low_cnt;
`endif
    end
  end

  // Output registers. They change on the same edge as the state.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pll_rst   <= w_pll_rst;
      r_sys_rst   <= w_sys_rst;
      r_ready     <= w_ready;
      r_lock_lost <= w_lock_loss;
      r_fault     <= w_fault;
    end
  end

  assign io_sup.pll_rst     = r_pll_rst;
  assign io_sup.sys_rst     = r_sys_rst;
  assign io_sup.ready       = r_ready;
  assign io_sup.lock_lost   = r_lock_lost;
  assign io_sup.fault       = r_fault;
  assign io_sup.retry_count = r_retry;

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequencing and health monitor for the clock PLL, running in the 50 MHz reference clock domain. It drives the PLL reset and consumes the PLL lock output. It withholds the system reset until lock has been stable, and re-sequences the PLL on timeout or lock loss. After a bounded number of failed attempts it latches a fault.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16, cycles pll_rst is held high per attempt (≥2)
- LOCK_TIMEOUT_CYCLES, 50000, max cycles waiting for lock per attempt (1 ms @ 50 MHz)
- LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
- RETRY_MAX, 7, failed attempts before FAULT (1..15)

Ports:
- refclk  in  1  50 MHz reference clock; only clock
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous; 2-flop synchronized internally
- pll_rst  out  1  PLL reset request
- sys_rst  out  1  downstream system reset, high until lock is stable
- ready  out  1  high only in RUN
- lock_lost  out  1  one-cycle pulse when lock drops in RUN
- fault  out  1  sticky; high in FAULT
- retry_count  out  4  failed attempts in current sequence, saturating at RETRY_MAX

## Operation
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT. `lk` = synchronized pll_locked.
- While rst is high:
  - State is RESET_PLL and all counters are 0.
  - Outputs: pll_rst=1, sys_rst=1, ready=0, lock_lost=0, fault=0, retry_count=0.
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - After RST_PULSE_CYCLES cycles, go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1; timer increments each cycle.
  - If lk=1, go to STABILIZE with the stable counter cleared.
  - Otherwise, if timer = LOCK_TIMEOUT_CYCLES-1, retry_count increments. If the new value equals RETRY_MAX, go to FAULT; else go to RESET_PLL.
  - If lk and timeout occur in the same cycle, lk wins.
- STABILIZE:
  - pll_rst=0, sys_rst=1.
  - If lk=0, return to WAIT_LOCK with the timer cleared. retry_count is unchanged; the timeout budget restarts.
  - After LOCK_STABLE_CYCLES consecutive lk=1 cycles, go to RUN.
- RUN:
  - sys_rst=0, ready=1; retry_count is cleared on entry.
  - On lock-loss detection:
    - lock_lost pulses for 1 cycle.
    - sys_rst=1 and ready=0 from the same cycle.
    - Next state is RESET_PLL.
- FAULT:
  - pll_rst=1, sys_rst=1, fault=1.
  - retry_count holds RETRY_MAX.
  - Exit only via rst.
- Counter widths are sized with $clog2 of each parameter. Counters never wrap; each is cleared on state entry.

## Timing
- All outputs are registered and change on the refclk edge where the state changes.
- pll_locked to lk latency: 2 cycles.
- rst deasserts at edge E:
  - pll_rst stays high through E+RST_PULSE_CYCLES-1.
  - pll_rst falls at edge E+RST_PULSE_CYCLES.
- Lock timeout fires LOCK_TIMEOUT_CYCLES cycles after WAIT_LOCK entry if lk stays 0.
- Minimum release latency from pll_locked rising (WAIT_LOCK) to sys_rst falling: 2 + 1 + LOCK_STABLE_CYCLES cycles.
- rst asserted mid-operation, in any state including FAULT: reset values apply at the next edge.

## Configuration
- PLL_SUPERVISOR_LOCK_FILTER_EN defined:
  - In RUN, lock loss is declared only after lk=0 for 4 consecutive cycles.
  - Shorter low glitches are ignored: no pulse, ready stays 1.
- Undefined: a single lk=0 cycle in RUN is lock loss.
- Applies to RUN only; STABILIZE always reacts to a single low cycle.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, RETRY_MAX=2.
1. Nominal: rst released, pll_locked raised 10 cycles after pll_rst falls, then held high.
   - Expect pll_rst high 4 cycles; sys_rst falls and ready rises 11 cycles after pll_locked rises; retry_count=0.
2. Timeout and retry: pll_locked held low.
   - Expect pll_rst low for 20 cycles, then high for 4 with retry_count=1.
   - After the second timeout expect fault=1, retry_count=2, pll_rst=1 held until rst.
3. STABILIZE glitch: pll_locked low for 1 cycle, 5 cycles into STABILIZE.
   - Expect return to WAIT_LOCK, no sys_rst release, full 8-cycle stable count restarted.
4. RUN lock loss, macro undefined: pll_locked low for 1 cycle.
   - Expect lock_lost pulse width 1, ready=0, sys_rst=1, then a pll_rst 4-cycle pulse.
5. RUN lock loss, macro defined:
   - 3-cycle low: no lock_lost, ready stays 1.
   - 4-cycle low: lock_lost pulse and re-sequence.
6. rst mid-sequence: rst asserted in STABILIZE and again in FAULT.
   - Expect reset values on the next edge; the sequence restarts with a 4-cycle pll_rst pulse.
